// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller drives every control strobe; op and mem_ready come back in.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           instr_done, illegal_op, state
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
           alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: one state register, decoded control
// outputs, all strobes masked to 0 while resetn is low.
module multicycle_ctrl (
  input  logic                  clk,
  input  logic                  resetn,
  multicycle_ctrl_if.master     bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Unknown opcodes map back to FETCH; the illegal flag comes from this too.
  function automatic logic [3:0] decode_next(input logic [5:0] opc);
    case (opc)
      OP_LW, OP_SW: decode_next = MEMADR;
      OP_RTYPE:     decode_next = EXECUTE;
      OP_BEQ:       decode_next = BRANCH;
      OP_ADDI:      decode_next = ADDIEXEC;
      OP_J:         decode_next = JUMP;
      default:      decode_next = FETCH;
    endcase
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_s;
  logic       mem_req_s, iord_s, memwrite_s, irwrite_s, pcwrite_s, branch_s;
  logic [1:0] pcsrc_s, alusrcb_s, aluop_s;
  logic       alusrca_s, regdst_s, memtoreg_s, regwrite_s;
  logic       instr_done_s, illegal_op_s;

  // State register, asynchronously forced to FETCH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; mem_ready is only consulted in the three memory states.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:    next_s = bus.mem_ready ? DECODE : FETCH;
      DECODE:   next_s = decode_next(bus.op);
      MEMADR:   next_s = (bus.op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    next_s = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:    next_s = FETCH;
      MEMWR:    next_s = bus.mem_ready ? FETCH : MEMWR;
      EXECUTE:  next_s = ALUWB;
      ALUWB:    next_s = FETCH;
      BRANCH:   next_s = FETCH;
      ADDIEXEC: next_s = ADDIWB;
      ADDIWB:   next_s = FETCH;
      JUMP:     next_s = FETCH;
      default:  next_s = FETCH;
    endcase
  end

  // Control decode; anything not set in a state stays 0, codes 12-15 included.
  always_comb begin
    mem_req_s    = 1'b0;
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    pcsrc_s      = 2'b00;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    aluop_s      = 2'b00;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    instr_done_s = 1'b0;
    illegal_op_s = 1'b0;
    case (state_r)
      FETCH: begin
        mem_req_s = 1'b1;
        alusrcb_s = 2'b01;
        irwrite_s = bus.mem_ready;
        pcwrite_s = bus.mem_ready;
      end
      DECODE: begin
        alusrcb_s = 2'b11;
        if (decode_next(bus.op) == FETCH) begin
          illegal_op_s = 1'b1;
          instr_done_s = 1'b1;
        end else begin
          illegal_op_s = 1'b0;
          instr_done_s = 1'b0;
        end
      end
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      MEMRD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      MEMWB: begin
        memtoreg_s   = 1'b1;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      MEMWR: begin
        mem_req_s    = 1'b1;
        iord_s       = 1'b1;
        memwrite_s   = 1'b1;
        instr_done_s = bus.mem_ready;
      end
      EXECUTE: begin
        alusrca_s = 1'b1;
        aluop_s   = 2'b10;
      end
      ALUWB: begin
        regdst_s     = 1'b1;
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      BRANCH: begin
        alusrca_s    = 1'b1;
        aluop_s      = 2'b01;
        pcsrc_s      = 2'b01;
        branch_s     = 1'b1;
        instr_done_s = 1'b1;
      end
      ADDIEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      ADDIWB: begin
        regwrite_s   = 1'b1;
        instr_done_s = 1'b1;
      end
      JUMP: begin
        pcsrc_s      = 2'b10;
        pcwrite_s    = 1'b1;
        instr_done_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Outputs gated by resetn so strobes drop without waiting for a clock.
  assign bus.mem_req    = mem_req_s    & resetn;
  assign bus.iord       = iord_s       & resetn;
  assign bus.memwrite   = memwrite_s   & resetn;
  assign bus.irwrite    = irwrite_s    & resetn;
  assign bus.pcwrite    = pcwrite_s    & resetn;
  assign bus.branch     = branch_s     & resetn;
  assign bus.pcsrc      = pcsrc_s      & {2{resetn}};
  assign bus.alusrca    = alusrca_s    & resetn;
  assign bus.alusrcb    = alusrcb_s    & {2{resetn}};
  assign bus.aluop      = aluop_s      & {2{resetn}};
  assign bus.regdst     = regdst_s     & resetn;
  assign bus.memtoreg   = memtoreg_s   & resetn;
  assign bus.regwrite   = regwrite_s   & resetn;
  assign bus.instr_done = instr_done_s & resetn;
  assign bus.illegal_op = illegal_op_s & resetn;
  assign bus.state      = state_r;

endmodule
